// File: rtl/bitrev_addr_gen.sv
// Per-frame address sequencer for the radix-2 FFT sample buffer.
// Streams 2^n addresses in natural or bit-reversed order over valid/ready.
module bitrev_addr_gen #(
    parameter int unsigned MAX_LOG2N    = 10,
    parameter bit          DEFAULT_MODE = 1'b1,
    localparam int unsigned LW          = $clog2(MAX_LOG2N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 cfg_override,
    input  logic [LW-1:0]        log2n_in,
    input  logic                 mode_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAX_LOG2N-1:0] addr,
    output logic [MAX_LOG2N-1:0] count,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [LW-1:0]        cfg_log2n
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [MAX_LOG2N-1:0] count_nxt;
    logic [LW-1:0]        log2n_nxt;
    logic [LW-1:0]        log2n_clamped;
    logic                 mode_q;
    logic                 mode_nxt;
    logic                 valid_nxt;
    logic                 done_nxt;
    logic [MAX_LOG2N-1:0] count_max;
    logic [MAX_LOG2N-1:0] rev_full;
    logic [LW-1:0]        shamt;
    logic                 is_last;
    logic                 fire;

    // Exponent clamp into the legal range 1..MAX_LOG2N
    always_comb begin
        log2n_clamped = log2n_in;
        if (log2n_in == '0) begin
            log2n_clamped = LW'(1);
        end else if (log2n_in > LW'(MAX_LOG2N)) begin
            log2n_clamped = LW'(MAX_LOG2N);
        end
    end

    // Terminal count 2^n-1 as a low-bit mask; reversal across full width then
    // shifted down so it spans only the latched n bits.
    always_comb begin
        count_max = '0;
        rev_full  = '0;
        for (int i = 0; i < int'(MAX_LOG2N); i++) begin
            count_max[i] = (i < int'(cfg_log2n));
            rev_full[i]  = count[int'(MAX_LOG2N) - 1 - i];
        end
    end

    assign shamt    = LW'(MAX_LOG2N) - cfg_log2n;
    assign addr     = mode_q ? (rev_full >> shamt) : count;
    assign is_last  = (count == count_max);
    assign out_last = out_valid && is_last;
    assign fire     = out_valid && out_ready;
    assign busy     = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            cfg_log2n <= '0;
            mode_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= valid_nxt;
            done      <= done_nxt;
            count     <= count_nxt;
            cfg_log2n <= log2n_nxt;
            mode_q    <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = out_valid;
        done_nxt  = 1'b0;
        count_nxt = count;
        log2n_nxt = cfg_log2n;
        mode_nxt  = mode_q;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = RUN;
                    valid_nxt = 1'b1;
                    count_nxt = '0;
                    log2n_nxt = log2n_clamped;
                    mode_nxt  = cfg_override ? mode_in : DEFAULT_MODE;
                end
            end
            RUN: begin
                // Abort outranks a same-cycle final transfer: no done pulse
                if (abort) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    count_nxt = '0;
                end else if (fire) begin
                    if (is_last) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        count_nxt = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        count_nxt = count + MAX_LOG2N'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule
